// File: rtl/park_pkg.sv
// Shared types and helpers for the parking gate controller.
package park_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSE   = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/park_timer.sv
// Loadable saturating down-counter; done is high while the count sits at zero.
module park_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) cnt_d = load_val_i;
    else if (cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/park_ctrl.sv
// Single-lane parking gate controller: password entry, retry lockout,
// open-gate timeout and lot occupancy counting.
//   state   | meaning
//   IDLE    | waiting for a car at the entry gate
//   CHECK   | requesting / checking a password
//   OPEN    | gate held open until the car passes or the timer expires
//   CLOSE   | one-cycle gate close command
//   LOCKOUT | alarm after too many wrong entries, inputs ignored
module park_ctrl
  import park_pkg::*;
#(
  parameter int               CAPACITY    = 8,
  parameter int               PWD_W       = 4,
  parameter logic [PWD_W-1:0] PASSWORD    = 4'b1011,
  parameter int               MAX_TRIES   = 3,
  parameter int               OPEN_CYCLES = 16,
  parameter int               LOCK_CYCLES = 64,
  parameter int               CW          = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_entry,
  input  logic             sensor_pass,
  input  logic             sensor_exit,
  input  logic             pwd_valid,
  input  logic [PWD_W-1:0] pwd_in,
  output logic             pwd_rqst,
  output logic             gate_open,
  output logic             gate_close,
  output logic             alarm,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int TW  = $clog2(max_int(OPEN_CYCLES, LOCK_CYCLES) + 1);
  localparam int TRW = $clog2(MAX_TRIES + 1);

  state_t         state_q, state_d;
  logic [TRW-1:0] tries_q, tries_d;
  logic [CW-1:0]  count_q, count_d;
  logic           tmr_load, tmr_done;
  logic [TW-1:0]  tmr_val;
  logic           inc, dec;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    case (state_q)
      S_IDLE: if (sensor_entry && !full) state_d = S_CHECK;
      S_CHECK: begin
        if (pwd_valid) begin
          if (pwd_in == PASSWORD) begin
            state_d = S_OPEN;
            tries_d = '0;
          end else begin
            tries_d = tries_q + TRW'(1);
            if (tries_d == TRW'(MAX_TRIES)) state_d = S_LOCKOUT;
          end
        end else if (!sensor_entry) begin
          state_d = S_IDLE;
        end
      end
      S_OPEN:  if (sensor_pass || tmr_done) state_d = S_CLOSE;
      S_CLOSE: state_d = S_IDLE;
      S_LOCKOUT: begin
        if (tmr_done) begin
          state_d = S_IDLE;
          tries_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pwd_rqst   = (state_q == S_CHECK);
    gate_open  = (state_q == S_OPEN);
    gate_close = (state_q == S_CLOSE);
    alarm      = (state_q == S_LOCKOUT);
  end

  // Timer is loaded with N-1 so the state lasts exactly N cycles.
  assign tmr_load = (state_d != state_q) &&
                    (state_d == S_OPEN || state_d == S_LOCKOUT);
  assign tmr_val  = (state_d == S_OPEN) ? TW'(OPEN_CYCLES - 1)
                                        : TW'(LOCK_CYCLES - 1);

  park_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign inc = (state_q == S_OPEN) && sensor_pass;
  assign dec = sensor_exit;

  always_comb begin
    count_d = count_q;
    case ({inc, dec})
      2'b10: if (count_q != CW'(CAPACITY)) count_d = count_q + CW'(1);
      2'b01: if (count_q != '0) count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tries_q <= '0;
      count_q <= '0;
    end else begin
      tries_q <= tries_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == CW'(CAPACITY));

endmodule

// File: doc/park_ctrl.md
# park_ctrl

Parametrised single-lane parking gate controller with password entry, retry lockout, an open-gate timeout and a lot occupancy counter. It sits between the lane sensors/keypad front end and the gate actuator drivers. A full lot refuses entry. A second sensor decrements occupancy as cars leave.

## Interface
- `CAPACITY`, 8: number of spaces; `full` asserts when `count == CAPACITY`.
- `PWD_W`, 4: password width in bits.
- `PASSWORD`, 4'b1011: accepted password, `PWD_W` bits.
- `MAX_TRIES`, 3: consecutive wrong entries that trigger lockout (≥1).
- `OPEN_CYCLES`, 16: gate-open timeout in clk cycles (≥2).
- `LOCK_CYCLES`, 64: lockout/alarm duration in clk cycles (≥2).
- `CW`, derived: `$clog2(CAPACITY+1)`, width of `count`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `sensor_entry` in 1: car present at the entry gate (level).
- `sensor_pass` in 1: car has passed beyond the gate (level).
- `sensor_exit` in 1: car leaving the lot (one-cycle pulse per car).
- `pwd_valid` in 1: `pwd_in` is valid this cycle (one-cycle strobe).
- `pwd_in` in `PWD_W`: entered password.
- `pwd_rqst` out 1: controller is waiting for a password.
- `gate_open` out 1: drive the gate open.
- `gate_close` out 1: drive the gate closed (one-cycle command).
- `alarm` out 1: lockout active.
- `full` out 1: lot full.
- `count` out `CW`: current occupancy.

## Operation
- States are IDLE, CHECK, OPEN, CLOSE and LOCKOUT.
- `pwd_rqst`, `gate_open`, `gate_close` and `alarm` are Moore outputs. They are decoded from the state register only: CHECK→`pwd_rqst`, OPEN→`gate_open`, CLOSE→`gate_close`, LOCKOUT→`alarm`.
- **IDLE:** if `sensor_entry && !full`, go to CHECK. Otherwise stay. `sensor_entry` while `full` is ignored.
- **CHECK:**
  - `pwd_valid` with `pwd_in == PASSWORD`: go to OPEN, clear `tries`.
  - `pwd_valid` with a mismatch: increment `tries`. If the new value equals `MAX_TRIES`, go to LOCKOUT. Otherwise stay.
  - `sensor_entry` low and no `pwd_valid`: the car has left. Go to IDLE; `tries` is kept.
- **OPEN:**
  - `sensor_pass`: go to CLOSE, `count` +1.
  - Otherwise, after `OPEN_CYCLES` cycles in OPEN: go to CLOSE with no count change.
- **CLOSE:** lasts exactly one cycle, then go to IDLE.
- **LOCKOUT:** lasts `LOCK_CYCLES` cycles, then go to IDLE with `tries` cleared. All inputs except `rst` and `sensor_exit` are ignored.
- **Exit path:** `sensor_exit` decrements `count` in any state. It saturates at 0.
- **Simultaneous increment and exit:** if a `sensor_pass` increment and a `sensor_exit` land in the same cycle, `count` is unchanged.
- **Increment when full:** the increment saturates at `CAPACITY`. This is unreachable under correct sensors.
- **Reset:** `rst` forces IDLE, `tries=0`, `count=0`, timer=0. Every output is 0 after reset. Reset mid-OPEN drops the gate at once, with no CLOSE pulse.

## Timing
- `sensor_entry` sampled high at edge k: `pwd_rqst` is high from edge k to edge k+1 and onward.
- Correct `pwd_valid` at edge k: `pwd_rqst` falls and `gate_open` rises after edge k.
- `sensor_pass` at edge k: after k, `gate_close`=1 and `count` is updated for exactly one cycle. After k+1, `gate_close`=0 and the state is IDLE.
- Timeout: `gate_open` stays high for exactly `OPEN_CYCLES` cycles, then `gate_close` pulses for 1 cycle.
- `alarm` stays high for exactly `LOCK_CYCLES` cycles.
- `full` is combinational from the `count` register, so it has no extra latency.

## Structure
- Package `park_pkg` holds the state encoding enum (IDLE=0, CHECK=1, OPEN=2, CLOSE=3, LOCKOUT=4, 3 bits).
- Sub-module `park_timer` is a loadable down-counter with a `done` flag, width `$clog2(max(OPEN_CYCLES,LOCK_CYCLES)+1)`.
  - It is shared by OPEN and LOCKOUT.
  - It is loaded on entry to each state.

## Test plan
- **Happy path:** reset, `sensor_entry`=1, `pwd_valid` with `pwd_in`=4'b1011, then `sensor_pass` 3 cycles later → `gate_open` high for 3 cycles, one `gate_close` pulse, `count`=1.
- **Lockout:** 3 wrong passwords (4'b0000) → `alarm` high for exactly 64 cycles, then IDLE. The following correct password opens the gate.
- **Timeout:** correct password with no `sensor_pass` → `gate_open` high for 16 cycles, `gate_close` pulse, `count` unchanged.
- **Full lot:** with `CAPACITY`=2, admit 2 cars → `full`=1 and `sensor_entry` yields no `pwd_rqst`. One `sensor_exit` → `full`=0 and `count`=1.
- **Simultaneous events and saturation:** `sensor_pass` and `sensor_exit` in the same cycle → `count` unchanged. `sensor_exit` at `count`=0 → stays 0.
- **Reset mid-OPEN:** `rst` during OPEN → next cycle all outputs 0, `count`=0, state IDLE.
